// File: rtl/kmeans_acc_update_block.sv
// rtl/kmeans_acc_update_block.sv - k-means per-centroid accumulator with sequential centroid-update divider
//
// Purpose:
//   Accumulates per-centroid, per-dimension coordinate sums and per-centroid
//   sample counts from the distance pipeline. On update_start, a sequential
//   FSM computes new_centroid[k][d] = sum[k][d] / count[k] with a restoring
//   divider (one quotient bit per cycle), then clears the accumulators.
//
// Optional build macro:
//   KMEANS_ACC_ROUND_EN - when defined, the dividend is sum + (count>>1), giving
//                         round-half-up; when undefined, the quotient truncates.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   sample present on in_data/in_sel
//   in_ready       out  block accepts samples (FSM idle)
//   in_data        in   DIMS*DATA_W sample, dim d at [d*DATA_W +: DATA_W]
//   in_sel         in   SEL_W centroid index for the sample
//   old_centroids  in   K*DIMS*DATA_W current centroids, element (k,d) at k*DIMS+d
//   update_start   in   pulse: begin computing new centroids
//   busy           out  FSM not idle
//   done           out  pulse: new_centroids complete
//   new_centroids  out  K*DIMS*DATA_W computed centroids, same packing as old_centroids
//   overflow       out  sticky: a sample was dropped because its counter was saturated

module kmeans_acc_update_block #(
    parameter int K      = 2,
    parameter int DIMS   = 2,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = 16,
    parameter int SEL_W  = $clog2(K)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIMS*DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [K*DIMS*DATA_W-1:0]   old_centroids,
    input  logic                       update_start,
    output logic                       busy,
    output logic                       done,
    output logic [K*DIMS*DATA_W-1:0]   new_centroids,
    output logic                       overflow
);

    localparam int NE  = K * DIMS;
    localparam int E_W = $clog2(NE);
    localparam int D_W = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int B_W = $clog2(ACC_W + 1);
    localparam logic [SEL_W:0] K_SEL = (SEL_W + 1)'(K);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic [ACC_W-1:0]           r_sum [NE];
    logic [CNT_W-1:0]           r_cnt [K];
    logic [K*DIMS*DATA_W-1:0]   r_new;
    logic                       r_overflow;

    // Element walk: r_k/r_d are the (centroid, dimension) pair, r_e the flat index.
    logic [SEL_W-1:0]           r_k;
    logic [D_W-1:0]             r_d;
    logic [E_W-1:0]             r_e;

    // Divider: r_q starts as the dividend and shifts into the quotient.
    logic [ACC_W-1:0]           r_q;
    logic [CNT_W-1:0]           r_rem;
    logic [CNT_W-1:0]           r_div;
    logic [B_W-1:0]             r_bit;

    logic                       w_accept;
    logic                       w_sel_ok;
    logic                       w_cnt_full;
    logic                       w_take;
    logic [ACC_W-1:0]           w_sum_sel;
    logic [DATA_W-1:0]          w_old_sel;
    logic [CNT_W-1:0]           w_cnt_sel;
    logic [ACC_W-1:0]           w_dividend;
    logic                       w_last_e;
    logic                       w_last_d;
    logic [CNT_W:0]             w_trial;
    logic                       w_ge;
    logic [CNT_W-1:0]           w_rem_next;
    logic [DATA_W-1:0]          w_res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (update_start) w_next = S_LOAD;
            // Empty cluster skips the divide and keeps its old centroid.
            S_LOAD:  w_next = (w_cnt_sel == '0) ? S_STORE : S_DIV;
            S_DIV:   if (r_bit == '0) w_next = S_STORE;
            S_STORE: w_next = w_last_e ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (r_state != S_IDLE);
        in_ready = (r_state == S_IDLE);
        done     = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Accumulator-side decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = in_valid && in_ready;
        w_sel_ok   = ({1'b0, in_sel} < K_SEL);
        w_cnt_full = 1'b0;
        for (int k = 0; k < K; k++) begin
            if (in_sel == SEL_W'(k)) w_cnt_full = &r_cnt[k];
        end
        w_take = w_accept && w_sel_ok && !w_cnt_full;
    end

    // ------------------------------------------------------------------
    // Element operand selection for the current (k,d)
    // ------------------------------------------------------------------
    always_comb begin
        w_sum_sel = '0;
        w_old_sel = '0;
        for (int i = 0; i < NE; i++) begin
            if (r_e == E_W'(i)) begin
                w_sum_sel = r_sum[i];
                w_old_sel = old_centroids[i*DATA_W +: DATA_W];
            end
        end
        w_cnt_sel = '0;
        for (int k = 0; k < K; k++) begin
            if (r_k == SEL_W'(k)) w_cnt_sel = r_cnt[k];
        end
`ifdef KMEANS_ACC_ROUND_EN
        // ACC_W >= DATA_W+CNT_W leaves headroom for the half-divisor term.
        w_dividend = w_sum_sel + ACC_W'(w_cnt_sel >> 1);
`else
        w_dividend = w_sum_sel;
`endif
        w_last_e = (r_e == E_W'(NE - 1));
        w_last_d = (r_d == D_W'(DIMS - 1));
    end

    // ------------------------------------------------------------------
    // Restoring divide step and result saturation
    // ------------------------------------------------------------------
    always_comb begin
        // Remainder stays below the divisor, so CNT_W+1 bits hold the trial value.
        w_trial    = {r_rem, r_q[ACC_W-1]};
        w_ge       = (w_trial >= {1'b0, r_div});
        w_rem_next = w_ge ? CNT_W'(w_trial - {1'b0, r_div}) : CNT_W'(w_trial);
        w_res      = (|r_q[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : r_q[DATA_W-1:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) r_sum[i] <= '0;
            for (int k = 0; k < K; k++)  r_cnt[k] <= '0;
            r_new      <= '0;
            r_overflow <= 1'b0;
            r_k        <= '0;
            r_d        <= '0;
            r_e        <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_bit      <= '0;
        end else begin
            // Accumulation only happens while idle (in_ready gates w_accept).
            if (w_take) begin
                for (int k = 0; k < K; k++) begin
                    if (in_sel == SEL_W'(k)) begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                        for (int d = 0; d < DIMS; d++) begin
                            r_sum[k*DIMS+d] <= r_sum[k*DIMS+d]
                                             + ACC_W'(in_data[d*DATA_W +: DATA_W]);
                        end
                    end
                end
            end
            if (w_accept && w_sel_ok && w_cnt_full) begin
                r_overflow <= 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (update_start) begin
                        r_k <= '0;
                        r_d <= '0;
                        r_e <= '0;
                    end
                end
                S_LOAD: begin
                    r_rem <= '0;
                    r_div <= w_cnt_sel;
                    r_bit <= B_W'(ACC_W - 1);
                    // For an empty cluster the old centroid rides through r_q to STORE.
                    r_q   <= (w_cnt_sel == '0) ? ACC_W'(w_old_sel) : w_dividend;
                end
                S_DIV: begin
                    r_q   <= {r_q[ACC_W-2:0], w_ge};
                    r_rem <= w_rem_next;
                    r_bit <= r_bit - B_W'(1);
                end
                S_STORE: begin
                    for (int i = 0; i < NE; i++) begin
                        if (r_e == E_W'(i)) r_new[i*DATA_W +: DATA_W] <= w_res;
                    end
                    r_e <= r_e + E_W'(1);
                    if (w_last_d) begin
                        r_d <= '0;
                        r_k <= r_k + SEL_W'(1);
                    end else begin
                        r_d <= r_d + D_W'(1);
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < NE; i++) r_sum[i] <= '0;
                    for (int k = 0; k < K; k++)  r_cnt[k] <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign new_centroids = r_new;
    assign overflow      = r_overflow;

endmodule

// File: doc/kmeans_acc_update_block.md
Name: kmeans_acc_update_block

Overview:
- Parametrised successor to the fixed 2-centroid/2-dimension accumulator block.
- Accumulates per-centroid, per-dimension sums and sample counts from the k-means pipeline output, for any K centroids and D dimensions.
- On request, runs a sequential division FSM: new_centroid[k][d] = sum[k][d] / count[k].
- Sits between the distance pipeline and the top-level centroid registers; closes the k-means iteration loop in hardware.

Parameters:
- K, 2, number of centroids (≥2)
- DIMS, 2, number of dimensions (≥1)
- DATA_W, 8, bits per coordinate, unsigned
- CNT_W, 8, bits per centroid sample counter
- ACC_W, 16, accumulator width; must be ≥ DATA_W+CNT_W
- SEL_W, $clog2(K), centroid index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on in_data/in_sel
- in_ready  out  1  block accepts samples (= !busy)
- in_data  in  DIMS*DATA_W  sample; dim d at bits [d*DATA_W +: DATA_W]
- in_sel  in  SEL_W  selected centroid for the sample
- old_centroids  in  K*DIMS*DATA_W  current centroids; element (k,d) at index k*DIMS+d
- update_start  in  1  1-cycle pulse; begin computing new centroids
- busy  out  1  FSM not IDLE
- done  out  1  1-cycle pulse; new_centroids complete
- new_centroids  out  K*DIMS*DATA_W  computed centroids, same packing as old_centroids
- overflow  out  1  sticky; a sample was dropped because its counter was saturated

Behaviour:
- Reset (async, rst_n=0):
  - All sums, counters and new_centroids cleared to 0.
  - FSM to IDLE; busy=0, done=0, overflow=0, in_ready=1.
- Accumulate (IDLE only):
  - A sample is accepted when in_valid && in_ready.
  - On acceptance: sum[in_sel][d] += in_data[d] for every d, and count[in_sel] += 1.
  - All accumulation is zero-extended to ACC_W.
  - If count[in_sel] == 2^CNT_W-1, the sample is dropped (sums and count unchanged) and overflow is set.
  - in_sel ≥ K: sample ignored, nothing flagged.
- update_start in IDLE:
  - A sample accepted in the same cycle is included in the update.
  - FSM goes to LOAD with k=0, d=0.
  - update_start while busy is ignored.
- FSM states:
  - IDLE: accumulate as above.
  - LOAD (1 cycle):
    - If count[k]==0, go to STORE with the result forced to old_centroids(k,d) (empty cluster keeps its previous centroid).
    - Otherwise load the dividend sum[k][d] (see Optional Feature) and divisor count[k], then go to DIV.
  - DIV (exactly ACC_W cycles): restoring unsigned divide, one quotient bit per cycle, MSB first.
  - STORE (1 cycle):
    - Write the quotient into new_centroids(k,d); if it exceeds 2^DATA_W-1, saturate to 2^DATA_W-1.
    - Advance d; on wrap, d=0 and k++.
    - Go to LOAD if more elements remain, else DONE.
  - DONE (1 cycle):
    - done=1.
    - Clear all sums and counters; overflow is kept.
    - Go to IDLE.
- Latency, update_start to done:
  - 1 + Σ over elements of (2 if count==0 else ACC_W+2) cycles, including the DONE cycle.
  - Example: K=2, DIMS=2, ACC_W=16, both clusters non-empty → 1+4·18 = 73 cycles.
- new_centroids:
  - Changes only at STORE and holds its value otherwise.
  - Partially updated while busy; valid only from the done cycle onward.
- overflow clears only on reset.
- Reset mid-update: immediate abort to the reset state; no done pulse.

Optional Feature:
- Macro: KMEANS_ACC_ROUND_EN.
- Defined: the dividend at LOAD is sum + (count>>1), giving round-half-up to nearest; ACC_W carries the extra term without wrap.
- Undefined: the dividend is sum, giving truncation.
- Latency is identical in both builds.

Test Plan (K=2, DIMS=2, DATA_W=8, CNT_W=8, ACC_W=16):
- Truncation/rounding:
  - Stimulus: samples (10,21)->k0 and (11,22)->k0; old_centroids all 0xFF; then update_start.
  - Required without macro: k0=(10,21); with macro: k0=(11,22).
  - Required in both builds: k1 stays (0xFF,0xFF) because count=0; done pulses exactly once.
- Latency:
  - Stimulus: one sample per cluster, (4,6)->k0 and (8,2)->k1; then update_start.
  - Required: done exactly 73 cycles after the start edge; k0=(4,6), k1=(8,2); busy high throughout, in_ready low.
- Handshake and simultaneous events:
  - Stimulus: in_valid while busy.
  - Required: sample not accumulated.
  - Stimulus: in_valid together with update_start in IDLE.
  - Required: sample included; e.g. (100,50)->k1 alone gives k1=(100,50).
- Saturation:
  - Stimulus: 256 samples of (1,1)->k0.
  - Required: the 256th sample is dropped and overflow=1; k0 result=(1,1) with count 255.
  - Stimulus: a further update round.
  - Required: overflow still 1.
- Clear after update:
  - Stimulus: a second update_start with no new samples.
  - Required: both clusters keep old_centroids; done at 1+4·2 = 9 cycles.
- Async reset mid-DIV:
  - Stimulus: assert rst_n=0 during DIV, between clock edges.
  - Required: outputs zero immediately with no done; after release, accumulation restarts from zero.
